// File: rtl/mem_controller_pkg.sv
// Shared definitions for the byte-serial memory controller: widths, access-size
// encodings, the IO window base and the controller state encoding.
package mem_controller_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_BITS  = 32;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  localparam logic [31:0] IO_ADDR = 32'h0003_0000;
  localparam int          IO_SPAN = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mc_state_e;

  typedef enum logic {
    OWN_LSU = 1'b0,
    OWN_IF  = 1'b1
  } mc_owner_e;

  // Width code 2'b11 is served as a full word.
  function automatic logic [2:0] byte_count(input logic [1:0] width);
    case (width)
      WIDTH_B: return 3'd1;
      WIDTH_H: return 3'd2;
      WIDTH_W: return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_controller.sv
// Memory controller: arbitrates LSU (priority) against instruction fetch and
// serialises each byte/half/word access onto the byte-wide RAM port.
module mem_controller #(
  parameter int                ADDR_W  = mem_controller_pkg::ADDR_BITS,
  parameter int                DATA_W  = mem_controller_pkg::DATA_WIDTH,
  parameter logic [ADDR_W-1:0] IO_ADDR = mem_controller_pkg::IO_ADDR
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              lsu2memCon_enable,
  input  logic              lsu2memCon_rw,
  input  logic [1:0]        lsu2memCon_width,
  input  logic [ADDR_W-1:0] lsu2memCon_addr,
  input  logic [DATA_W-1:0] lsu2memCon_data,
  output logic              memCon2lsu_enable,
  output logic [DATA_W-1:0] memCon2lsu_return,
  input  logic              if2memCon_enable,
  input  logic [ADDR_W-1:0] if2memCon_addr,
  output logic              memCon2if_enable,
  output logic [DATA_W-1:0] memCon2if_return,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  import mem_controller_pkg::*;

  mc_state_e         state;
  mc_owner_e         owner;
  logic [2:0]        cnt;
  logic [2:0]        nbytes;
  logic              lsu_ack_q;
  logic              if_ack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ret_q;

  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] io_off;
  logic              in_io;
  logic              stall;
  logic              can_accept;
  logic              accept_lsu;
  logic              accept_if;
  logic              rd_done;
  logic              wr_done;
  logic [7:0]        wr_byte;
  logic [DATA_W-1:0] rd_merged;

  always_comb begin
    cur_addr   = addr_q + ADDR_W'(cnt);
    io_off     = cur_addr - IO_ADDR;
    in_io      = io_off < ADDR_W'(IO_SPAN);
    stall      = (state == ST_WRITE) && in_io && io_buffer_full;
    // An ack still in flight means the requester may not have dropped enable yet.
    can_accept = (state == ST_IDLE) && !lsu_ack_q && !if_ack_q;
    accept_lsu = can_accept && lsu2memCon_enable;
    accept_if  = can_accept && !lsu2memCon_enable && if2memCon_enable;
    rd_done    = (state == ST_READ) && (cnt == nbytes);
    wr_done    = (state == ST_WRITE) && !stall && (cnt == nbytes - 3'd1);
    wr_byte    = wdata_q[{cnt[1:0], 3'b000} +: 8];
    // The byte on mem_din belongs to the address issued one cycle earlier.
    rd_merged  = rdata_q;
    if (state == ST_READ && cnt != 3'd0) begin
      rd_merged[{cnt[1:0] - 2'd1, 3'b000} +: 8] = mem_din;
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = 8'h00;
    if (state == ST_WRITE || (state == ST_READ && cnt < nbytes)) begin
      mem_a = cur_addr;
    end
    if (state == ST_WRITE) begin
      mem_dout = wr_byte;
    end
    mem_wr            = (state == ST_WRITE) && !stall && rdy_in;
    memCon2lsu_enable = lsu_ack_q && rdy_in;
    memCon2if_enable  = if_ack_q && rdy_in;
    memCon2lsu_return = memCon2lsu_enable ? ret_q : '0;
    memCon2if_return  = memCon2if_enable ? ret_q : '0;
  end

  // Control: state, byte index, ownership and ack flags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= ST_IDLE;
      owner     <= OWN_LSU;
      cnt       <= 3'd0;
      nbytes    <= 3'd1;
      lsu_ack_q <= 1'b0;
      if_ack_q  <= 1'b0;
    end else if (rdy_in) begin
      lsu_ack_q <= 1'b0;
      if_ack_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= 3'd0;
          if (accept_lsu) begin
            owner  <= OWN_LSU;
            nbytes <= byte_count(lsu2memCon_width);
            state  <= lsu2memCon_rw ? ST_WRITE : ST_READ;
          end else if (accept_if) begin
            owner  <= OWN_IF;
            nbytes <= 3'd4;
            state  <= ST_READ;
          end
        end
        ST_READ: begin
          if (rd_done) begin
            lsu_ack_q <= (owner == OWN_LSU);
            if_ack_q  <= (owner == OWN_IF);
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_WRITE: begin
          if (wr_done) begin
            lsu_ack_q <= (owner == OWN_LSU);
            if_ack_q  <= (owner == OWN_IF);
            state     <= ST_IDLE;
          end else if (!stall) begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: request capture, read assembly and return data
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (accept_lsu) begin
        addr_q  <= lsu2memCon_addr;
        wdata_q <= lsu2memCon_data;
        rdata_q <= '0;
      end else if (accept_if) begin
        addr_q  <= if2memCon_addr;
        wdata_q <= '0;
        rdata_q <= '0;
      end else if (state == ST_READ) begin
        rdata_q <= rd_merged;
      end
      if (rd_done) begin
        ret_q <= rd_merged;
      end else if (wr_done) begin
        ret_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a byte-wide RAM model and ack/write monitors.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        lsu2memCon_enable;
  logic        lsu2memCon_rw;
  logic [1:0]  lsu2memCon_width;
  logic [31:0] lsu2memCon_addr;
  logic [31:0] lsu2memCon_data;
  logic        memCon2lsu_enable;
  logic [31:0] memCon2lsu_return;
  logic        if2memCon_enable;
  logic [31:0] if2memCon_addr;
  logic        memCon2if_enable;
  logic [31:0] memCon2if_return;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk = ~clk;

  mem_controller dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .lsu2memCon_enable (lsu2memCon_enable),
    .lsu2memCon_rw     (lsu2memCon_rw),
    .lsu2memCon_width  (lsu2memCon_width),
    .lsu2memCon_addr   (lsu2memCon_addr),
    .lsu2memCon_data   (lsu2memCon_data),
    .memCon2lsu_enable (memCon2lsu_enable),
    .memCon2lsu_return (memCon2lsu_return),
    .if2memCon_enable  (if2memCon_enable),
    .if2memCon_addr    (if2memCon_addr),
    .memCon2if_enable  (memCon2if_enable),
    .memCon2if_return  (memCon2if_return),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] a_s    = 32'h0;
  logic        wr_s   = 1'b0;
  logic [7:0]  dout_s = 8'h00;
  int wr_count    = 0;
  int lsu_ack_cnt = 0;
  int if_ack_cnt  = 0;
  int checks      = 0;
  int fails       = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  // Bus is sampled mid-cycle; the RAM acts on those samples at the next edge.
  always @(negedge clk) begin
    a_s    = mem_a;
    wr_s   = mem_wr;
    dout_s = mem_dout;
    if (mem_wr === 1'b1) wr_count++;
    if (memCon2lsu_enable === 1'b1) lsu_ack_cnt++;
    if (memCon2if_enable === 1'b1) if_ack_cnt++;
  end

  always @(posedge clk) begin
    mem_din <= ram_rd(a_s);
    if (wr_s) ram[a_s] = dout_s;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lsu_req(input logic rw, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] d);
    lsu2memCon_enable = 1'b1;
    lsu2memCon_rw     = rw;
    lsu2memCon_width  = w;
    lsu2memCon_addr   = a;
    lsu2memCon_data   = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    int i0;
    int l0;
    int ack_c;
    logic got;
    logic [31:0] if_ret;

    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    lsu2memCon_enable = 1'b0; lsu2memCon_rw = 1'b0; lsu2memCon_width = 2'b00;
    lsu2memCon_addr = 32'h0; lsu2memCon_data = 32'h0;
    if2memCon_enable = 1'b0; if2memCon_addr = 32'h0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h40]  = 8'h5A;
    ram[32'h80]  = 8'hDE; ram[32'h81]  = 8'hAD; ram[32'h82]  = 8'hBE; ram[32'h83]  = 8'hEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_dout", mem_dout, 8'h00);
    check("rst_lsu_ack", memCon2lsu_enable, 1'b0);
    check("rst_if_ack", memCon2if_enable, 1'b0);
    check("rst_lsu_ret", memCon2lsu_return, 32'h0);
    check("rst_if_ret", memCon2if_return, 32'h0);
    step(); rst_in = 1'b0;
    step();

    // Word load at 0x100
    step(); lsu_req(1'b0, 2'b10, 32'h100, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      step(); @(negedge clk);
      if (c <= 4) check("t1_mem_a", mem_a, 32'h100 + 32'(c - 1));
      if (c == 1) check("t1_mem_wr", mem_wr, 1'b0);
      check("t1_ack", memCon2lsu_enable, c == 6);
      if (c == 6) check("t1_ret", memCon2lsu_return, 32'h4433_2211);
    end
    step(); lsu2memCon_enable = 1'b0; @(negedge clk);
    check("t1_ack_drop", memCon2lsu_enable, 1'b0);

    // Half store of 0xABCD1234 at 0x200
    step(); lsu_req(1'b1, 2'b01, 32'h200, 32'hABCD_1234); w0 = wr_count;
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge clk);
      check("t2_mem_wr", mem_wr, c <= 2);
      if (c == 1) begin check("t2_a0", mem_a, 32'h200); check("t2_d0", mem_dout, 8'h34); end
      if (c == 2) begin check("t2_a1", mem_a, 32'h201); check("t2_d1", mem_dout, 8'h12); end
      check("t2_ack", memCon2lsu_enable, c == 3);
      if (c == 3) check("t2_ret", memCon2lsu_return, 32'h0);
    end
    step(); lsu2memCon_enable = 1'b0;
    step(); step();
    check("t2_write_count", 32'(wr_count - w0), 32'd2);
    check("t2_ram_200", ram_rd(32'h200), 8'h34);
    check("t2_ram_201", ram_rd(32'h201), 8'h12);

    // Simultaneous LSU byte load at 0x40 and IF fetch at 0x80
    step(); lsu_req(1'b0, 2'b00, 32'h40, 32'h0);
    if2memCon_enable = 1'b1; if2memCon_addr = 32'h80; i0 = if_ack_cnt;
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge clk);
      if (c == 1) check("t3_lsu_first", mem_a, 32'h40);
      check("t3_lsu_ack", memCon2lsu_enable, c == 3);
      check("t3_if_ack_early", memCon2if_enable, 1'b0);
      if (c == 3) check("t3_lsu_ret", memCon2lsu_return, 32'h0000_005A);
    end
    step(); lsu2memCon_enable = 1'b0;
    got = 1'b0; ack_c = 0; if_ret = 32'h0;
    for (int k = 5; k <= 30 && !got; k++) begin
      step(); @(negedge clk);
      if (memCon2if_enable) begin got = 1'b1; ack_c = k; if_ret = memCon2if_return; end
    end
    check("t3_if_ack_seen", got, 1'b1);
    check("t3_if_ack_cycle", 32'(ack_c), 32'd10);
    check("t3_if_ret", if_ret, 32'hEFBE_ADDE);
    step(); if2memCon_enable = 1'b0;
    repeat (4) step();
    check("t3_if_ack_once", 32'(if_ack_cnt - i0), 32'd1);

    // Byte store to the IO window with the buffer full for 3 cycles
    step(); io_buffer_full = 1'b1; lsu_req(1'b1, 2'b00, 32'h3_0000, 32'h41); w0 = wr_count;
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge clk);
      check("t4_stall_wr", mem_wr, 1'b0);
      check("t4_stall_a", mem_a, 32'h3_0000);
    end
    step(); io_buffer_full = 1'b0; @(negedge clk);
    check("t4_wr", mem_wr, 1'b1);
    check("t4_dout", mem_dout, 8'h41);
    step(); @(negedge clk);
    check("t4_ack", memCon2lsu_enable, 1'b1);
    step(); lsu2memCon_enable = 1'b0;
    step(); step();
    check("t4_write_count", 32'(wr_count - w0), 32'd1);
    check("t4_ram", ram_rd(32'h3_0000), 8'h41);

    // Reset in c2 of a word read
    step(); lsu_req(1'b0, 2'b10, 32'h100, 32'h0); l0 = lsu_ack_cnt;
    step(); @(negedge clk);
    check("t5_a_c1", mem_a, 32'h100);
    step(); rst_in = 1'b1; @(negedge clk);
    check("t5_a_c2", mem_a, 32'h101);
    step(); rst_in = 1'b0; lsu2memCon_enable = 1'b0; @(negedge clk);
    check("t5_post_a", mem_a, 32'h0);
    check("t5_post_wr", mem_wr, 1'b0);
    check("t5_post_dout", mem_dout, 8'h00);
    check("t5_post_ack", memCon2lsu_enable, 1'b0);
    check("t5_post_ret", memCon2lsu_return, 32'h0);
    repeat (8) step();
    check("t5_no_ack", 32'(lsu_ack_cnt - l0), 32'd0);
    lsu_req(1'b0, 2'b00, 32'h40, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      step(); @(negedge clk);
      check("t5_new_ack", memCon2lsu_enable, c == 3);
      if (c == 3) check("t5_new_ret", memCon2lsu_return, 32'h0000_005A);
    end
    step(); lsu2memCon_enable = 1'b0;
    step();

    // Word store with rdy_in low for 4 cycles
    step(); lsu_req(1'b1, 2'b10, 32'h300, 32'hCAFE_F00D); w0 = wr_count; l0 = lsu_ack_cnt;
    ack_c = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      rdy_in = !(c >= 2 && c <= 5);
      if (ack_c != 0) lsu2memCon_enable = 1'b0;
      @(negedge clk);
      if (c == 1) check("t6_wr_c1", mem_wr, 1'b1);
      if (c >= 2 && c <= 5) check("t6_wr_frozen", mem_wr, 1'b0);
      if (c == 6) check("t6_a_resume", mem_a, 32'h301);
      if (memCon2lsu_enable && ack_c == 0) ack_c = c;
    end
    step();
    check("t6_ack_cycle", 32'(ack_c), 32'd9);
    check("t6_ack_once", 32'(lsu_ack_cnt - l0), 32'd1);
    check("t6_write_count", 32'(wr_count - w0), 32'd4);
    check("t6_ram", {ram_rd(32'h303), ram_rd(32'h302), ram_rd(32'h301), ram_rd(32'h300)},
          32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
